restoring_divider_module: RTL and testbench

RESTORING_DIVIDER_MODULE -- requirements
Module: restoring_divider_module

---
 rtl/restoring_divider_module_pkg.sv | 15 +
 rtl/restoring_divider_module_step.sv | 19 +
 rtl/restoring_divider_module.sv | 124 ++++++++++++
 tb/tb_restoring_divider_module.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/restoring_divider_module_pkg.sv
// Shared constants and state encoding for the 8-bit signed restoring divider.
package restoring_divider_module_pkg;

  localparam int DATA_W = 8;
  localparam int ITER_N = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_ITER = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/restoring_divider_module_step.sv
// One combinational restoring-division step: shift in the next dividend bit, trial-subtract.
module divide_step_module (
  input  logic [8:0] rem,
  input  logic [7:0] quo,
  input  logic [7:0] dvs_mag,
  output logic [8:0] rem_next,
  output logic [7:0] quo_next
);

  logic [9:0] shifted;
  logic       ge;

  // The quotient register still holds unconsumed dividend bits in its upper end.
  assign shifted  = {rem, quo[7]};
  assign ge       = (shifted >= {2'b00, dvs_mag});
  assign rem_next = ge ? 9'(shifted - {2'b00, dvs_mag}) : shifted[8:0];
  assign quo_next = {quo[6:0], ge};

endmodule

// File: rtl/restoring_divider_module.sv
// 8-bit signed restoring divider: sign strip, eight shift/subtract steps, sign fix-up.
module restoring_divider_module
  import restoring_divider_module_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start_Sig,
  input  logic [7:0] Dividend,
  input  logic [7:0] Divisor,
  output logic       Done_Sig,
  output logic       Busy,
  output logic [7:0] Quotient,
  output logic [7:0] Remainder,
  output logic       Div_Zero,
  output logic       Overflow
);

  function automatic logic [DATA_W-1:0] neg_val(input logic [DATA_W-1:0] x);
    return ~x + 8'd1;
  endfunction

  // |-128| maps to 8'h80, which is exactly the unsigned magnitude we need.
  function automatic logic [DATA_W-1:0] mag_val(input logic signed [DATA_W-1:0] x);
    return x[DATA_W-1] ? neg_val(x) : x;
  endfunction

  state_t state_q, state_d;

  logic [2:0]              cnt_q;
  logic signed [DATA_W-1:0] dividend_q, divisor_q;
  logic                    sign_n_q, sign_d_q;
  logic [DATA_W-1:0]       dvs_mag_q;
  logic [DATA_W:0]         rem_q, rem_nx;
  logic [DATA_W-1:0]       quo_q, quo_nx;
  logic [DATA_W-1:0]       quotient_q, remainder_q;
  logic                    div_zero_q, overflow_q;

  divide_step_module u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .dvs_mag  (dvs_mag_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (Start_Sig) state_d = ST_PRE;
      ST_PRE:  state_d = ST_ITER;
      ST_ITER: if (cnt_q == 3'(ITER_N - 1)) state_d = ST_POST;
      ST_POST: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q       <= '0;
      dividend_q  <= '0;
      divisor_q   <= '0;
      sign_n_q    <= 1'b0;
      sign_d_q    <= 1'b0;
      dvs_mag_q   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Start_Sig) begin
            dividend_q <= Dividend;
            divisor_q  <= Divisor;
          end
        end
        ST_PRE: begin
          sign_n_q  <= dividend_q[DATA_W-1];
          sign_d_q  <= divisor_q[DATA_W-1];
          quo_q     <= mag_val(dividend_q);
          dvs_mag_q <= mag_val(divisor_q);
          rem_q     <= '0;
          cnt_q     <= '0;
        end
        ST_ITER: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          if (cnt_q != 3'(ITER_N - 1)) cnt_q <= cnt_q + 3'd1;
        end
        ST_POST: begin
          // Divide-by-zero bypasses the sign fix-up so Remainder echoes the raw dividend.
          if (divisor_q == '0) begin
            quotient_q  <= 8'hFF;
            remainder_q <= dividend_q;
            div_zero_q  <= 1'b1;
            overflow_q  <= 1'b0;
          end else begin
            quotient_q  <= (sign_n_q ^ sign_d_q) ? neg_val(quo_q) : quo_q;
            remainder_q <= sign_n_q ? neg_val(rem_q[DATA_W-1:0]) : rem_q[DATA_W-1:0];
            div_zero_q  <= 1'b0;
            overflow_q  <= (dividend_q == 8'sh80) && (divisor_q == 8'shFF);
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy      = (state_q != ST_IDLE);
  assign Done_Sig  = (state_q == ST_DONE);
  assign Quotient  = quotient_q;
  assign Remainder = remainder_q;
  assign Div_Zero  = div_zero_q;
  assign Overflow  = overflow_q;

endmodule

// File: tb/tb_restoring_divider_module.sv
// Directed-vector bench for restoring_divider_module: results, flags, latency, reset and back-to-back.
module tb_restoring_divider_module;

  logic       CLK;
  logic       RST;
  logic       Start_Sig;
  logic [7:0] Dividend;
  logic [7:0] Divisor;
  logic       Done_Sig;
  logic       Busy;
  logic [7:0] Quotient;
  logic [7:0] Remainder;
  logic       Div_Zero;
  logic       Overflow;

  int n_checks = 0;
  int n_errors = 0;

  restoring_divider_module dut (
    .CLK       (CLK),
    .RST       (RST),
    .Start_Sig (Start_Sig),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Done_Sig  (Done_Sig),
    .Busy      (Busy),
    .Quotient  (Quotient),
    .Remainder (Remainder),
    .Div_Zero  (Div_Zero),
    .Overflow  (Overflow)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Launch one operation, scramble operands while busy, then check latency and results.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er,
                        input logic edz, input logic eov, input string tag);
    int n;
    @(negedge CLK);
    Dividend  = a;
    Divisor   = b;
    Start_Sig = 1'b1;
    @(negedge CLK);
    Start_Sig = 1'b0;
    Dividend  = 8'h5A;
    Divisor   = 8'h03;
    check({tag, ".busy"}, 32'(Busy), 32'd1);
    n = 1;
    while (!Done_Sig && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check({tag, ".latency"}, 32'(n), 32'd11);
    check({tag, ".quo"}, 32'(Quotient), 32'(eq));
    check({tag, ".rem"}, 32'(Remainder), 32'(er));
    check({tag, ".dz"}, 32'(Div_Zero), 32'(edz));
    check({tag, ".ov"}, 32'(Overflow), 32'(eov));
    @(negedge CLK);
    check({tag, ".busy_after"}, 32'(Busy), 32'd0);
    check({tag, ".done_pulse"}, 32'(Done_Sig), 32'd0);
    check({tag, ".quo_hold"}, 32'(Quotient), 32'(eq));
  endtask

  initial begin
    int n;
    int t1;
    int done_seen;
    RST       = 1'b1;
    Start_Sig = 1'b0;
    Dividend  = 8'h00;
    Divisor   = 8'h00;
    repeat (3) @(negedge CLK);
    check("reset.busy", 32'(Busy), 32'd0);
    check("reset.done", 32'(Done_Sig), 32'd0);
    check("reset.quo", 32'(Quotient), 32'd0);
    check("reset.rem", 32'(Remainder), 32'd0);
    check("reset.flags", 32'({Div_Zero, Overflow}), 32'd0);
    RST = 1'b0;

    run_op(8'd100, 8'd7,  8'h0E, 8'h02, 1'b0, 1'b0, "p100_p7");
    run_op(8'h9C,  8'd7,  8'hF2, 8'hFE, 1'b0, 1'b0, "m100_p7");
    run_op(8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b0, "p100_m7");
    run_op(8'h9C,  8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, "m100_m7");
    run_op(8'h80,  8'hFF, 8'h80, 8'h00, 1'b0, 1'b1, "m128_m1");
    run_op(8'd5,   8'd0,  8'hFF, 8'h05, 1'b1, 1'b0, "p5_z");

    // Reset in the middle of ITER (counter = 4) must abandon the operation.
    @(negedge CLK);
    Dividend  = 8'd100;
    Divisor   = 8'd7;
    Start_Sig = 1'b1;
    @(negedge CLK);
    Start_Sig = 1'b0;
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("midrst.busy", 32'(Busy), 32'd0);
    check("midrst.done", 32'(Done_Sig), 32'd0);
    check("midrst.quo", 32'(Quotient), 32'd0);
    check("midrst.rem", 32'(Remainder), 32'd0);
    check("midrst.flags", 32'({Div_Zero, Overflow}), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      if (Done_Sig) done_seen++;
    end
    check("midrst.no_done", 32'(done_seen), 32'd0);
    run_op(8'd127, 8'd2, 8'h3F, 8'h01, 1'b0, 1'b0, "p127_p2");

    // Start held high across two operations; operands changed while busy.
    @(negedge CLK);
    Dividend  = 8'd50;
    Divisor   = 8'd5;
    Start_Sig = 1'b1;
    @(negedge CLK);
    Dividend  = 8'd9;
    Divisor   = 8'd4;
    n = 1;
    while (!Done_Sig && n < 20) begin
      @(negedge CLK);
      n++;
    end
    t1 = n;
    check("b2b.lat1", 32'(n), 32'd11);
    check("b2b.quo1", 32'(Quotient), 32'h0A);
    check("b2b.rem1", 32'(Remainder), 32'h00);
    @(negedge CLK);
    n++;
    check("b2b.idle_gap", 32'(Busy), 32'd0);
    @(negedge CLK);
    n++;
    check("b2b.reaccept", 32'(Busy), 32'd1);
    Dividend  = 8'h77;
    Divisor   = 8'h11;
    Start_Sig = 1'b0;
    while (!Done_Sig && n < 40) begin
      @(negedge CLK);
      n++;
    end
    check("b2b.spacing", 32'(n - t1), 32'd12);
    check("b2b.quo2", 32'(Quotient), 32'h02);
    check("b2b.rem2", 32'(Remainder), 32'h01);
    check("b2b.flags2", 32'({Div_Zero, Overflow}), 32'd0);

    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
